gate_tester: RTL and testbench

Hardware self-checking stimulus/response engine for any 2-input combinational gate block in the lab set. It is the driving-and-checking end of a gate's `a`/`b`/`y` interface: it applies all four input vectors in order, holds each vector for a programmable number of cycles, samples `y`, and compares it against an expected truth table. At the end of a run it reports pass/fail, an error count and a per-vector failure mask. It replaces a simulation-only stimulus sequence with a synthesizable checker usable on the board.

---
 rtl/gate_tester.sv | 149 ++++++++++++++
 tb/tb_gate_tester.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gate_tester.sv
// Self-checking stimulus/response engine for a 2-input combinational gate:
// walks {a,b} through 00..11, samples y at the end of each hold window, reports mismatches.
module gate_tester #(
  parameter logic [3:0]  TRUTH = 4'b1000,
  parameter int unsigned HOLD  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  function automatic logic vec_mismatch(input logic [3:0] truth,
                                        input logic [1:0] idx,
                                        input logic       y_val);
    return y_val != truth[idx];
  endfunction

  state_t     state_r, state_s;
  logic [1:0] vec_r, vec_s;
  logic [7:0] hcnt_r, hcnt_s;
  logic       a_s, b_s, busy_s, done_s, pass_s;
  logic [2:0] err_s;
  logic [3:0] fail_s;

  // Next-state and next-output logic for the run sequencer.
  always_comb begin
    state_s = state_r;
    vec_s   = vec_r;
    hcnt_s  = hcnt_r;
    a_s     = a;
    b_s     = b;
    busy_s  = busy;
    done_s  = 1'b0;
    pass_s  = pass;
    err_s   = err_count;
    fail_s  = fail_vec;

    case (state_r)
      ST_IDLE: begin
        a_s    = 1'b0;
        b_s    = 1'b0;
        busy_s = 1'b0;
        if (start) begin
          err_s   = 3'd0;
          fail_s  = 4'b0000;
          pass_s  = 1'b0;
          vec_s   = 2'd0;
          hcnt_s  = 8'd0;
          busy_s  = 1'b1;
          state_s = ST_APPLY;
        end else begin
          vec_s  = 2'd0;
          hcnt_s = 8'd0;
        end
      end

      ST_APPLY: begin
        busy_s = 1'b1;
        hcnt_s = hcnt_r + 8'd1;
        if (hcnt_r == HOLD_LAST) begin
          if (vec_mismatch(TRUTH, vec_r, y)) begin
            err_s         = err_count + 3'd1;
            fail_s[vec_r] = 1'b1;
          end else begin
            err_s = err_count;
          end
          // Verdict is registered together with done, so it uses the updated count.
          if (vec_r == 2'd3) begin
            state_s = ST_FIN;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            a_s     = 1'b0;
            b_s     = 1'b0;
            hcnt_s  = 8'd0;
            pass_s  = (err_s == 3'd0);
          end else begin
            vec_s      = vec_r + 2'd1;
            hcnt_s     = 8'd0;
            {a_s, b_s} = vec_r + 2'd1;
          end
        end else begin
          {a_s, b_s} = vec_r;
        end
      end

      ST_FIN: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        a_s     = 1'b0;
        b_s     = 1'b0;
        vec_s   = 2'd0;
        hcnt_s  = 8'd0;
      end

      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        a_s     = 1'b0;
        b_s     = 1'b0;
        vec_s   = 2'd0;
        hcnt_s  = 8'd0;
      end
    endcase
  end

  // State, counters and all outputs are registered; rst clears them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      vec_r     <= 2'd0;
      hcnt_r    <= 8'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'b0000;
    end else begin
      state_r   <= state_s;
      vec_r     <= vec_s;
      hcnt_r    <= hcnt_s;
      a         <= a_s;
      b         <= b_s;
      busy      <= busy_s;
      done      <= done_s;
      pass      <= pass_s;
      err_count <= err_s;
      fail_vec  <= fail_s;
    end
  end

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: table of gate models, randomized gates against a truth-table
// model, and hand sequences for start handling, reset abort and a latent XOR gate.
module tb_gate_tester;

  localparam int HOLD = 10;
  localparam logic [3:0] TRUTH = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start2;
  logic       y, y2;
  logic       a, b, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic       a2, b2, busy2, done2, pass2;
  logic [2:0] err_count2;
  logic [3:0] fail_vec2;
  logic [3:0] gate_tt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign y = gate_tt[{a, b}];

  // XOR gate with one registered stage of latency for the second tester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) y2 <= 1'b0;
    else     y2 <= a2 ^ b2;
  end

  gate_tester dut (
    .clk(clk), .rst(rst), .start(start), .y(y),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  gate_tester #(.TRUTH(4'b0110), .HOLD(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .y(y2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .fail_vec(fail_vec2)
  );

  typedef struct {
    string      name;
    logic [3:0] tt;
    logic [2:0] exp_err;
    logic [3:0] exp_fail;
    logic       exp_pass;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One run on the default tester with a pulsed start; checks timing, sequence and verdict.
  task automatic run_dut(input string name, input logic [3:0] tt,
                         input logic [2:0] exp_err, input logic [3:0] exp_fail,
                         input logic exp_pass);
    int cyc;
    int seq_err;
    gate_tt = tt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    chk({name, "_c1_busy"}, 32'(busy), 32'd1);
    chk({name, "_c1_clear"}, {27'd0, pass, err_count, fail_vec}, 32'd0);
    seq_err = 0;
    while (!done && cyc < 200) begin
      if (cyc <= 4 * HOLD) begin
        if ({a, b} !== 2'((cyc - 1) / HOLD) || busy !== 1'b1) seq_err++;
      end else begin
        seq_err++;
      end
      @(negedge clk);
      cyc++;
    end
    chk({name, "_ab_seq"}, 32'(seq_err), 32'd0);
    chk({name, "_done_cyc"}, 32'(cyc), 32'(4 * HOLD + 1));
    chk({name, "_result"}, {24'd0, pass, err_count, fail_vec},
        {24'd0, exp_pass, exp_err, exp_fail});
    @(negedge clk);
    chk({name, "_after"}, {29'd0, done, busy, a | b}, 32'd0);
  endtask

  vec_t tbl[4];

  initial begin
    int cyc, ndone, done_cyc;
    logic [3:0] rtt, exp_fail;

    tbl[0] = '{"and",    4'b1000, 3'd0, 4'b0000, 1'b1};
    tbl[1] = '{"stuck0", 4'b0000, 3'd1, 4'b1000, 1'b0};
    tbl[2] = '{"stuck1", 4'b1111, 3'd3, 4'b0111, 1'b0};
    tbl[3] = '{"nand",   4'b0111, 3'd4, 4'b1111, 1'b0};

    rst = 1'b1; start = 1'b0; start2 = 1'b0; gate_tt = 4'b1000;
    repeat (3) @(negedge clk);
    chk("reset_state", {21'd0, a, b, busy, done, pass, err_count, fail_vec}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_dut(tbl[i].name, tbl[i].tt, tbl[i].exp_err, tbl[i].exp_fail, tbl[i].exp_pass);

    // Verdict holds after the run until the next accepted start.
    repeat (5) @(negedge clk);
    chk("hold_result", {24'd0, pass, err_count, fail_vec}, {24'd0, 1'b0, 3'd4, 4'b1111});

    // Passing run right after a failing one: cycle-1 clear and a clean verdict.
    run_dut("and_after_fail", 4'b1000, 3'd0, 4'b0000, 1'b1);
    // Cycle-1 clear of pass after a passing run.
    run_dut("stuck0_after_pass", 4'b0000, 3'd1, 4'b1000, 1'b0);

    // Random gate models against the truth-table difference.
    for (int i = 0; i < 6; i++) begin
      rtt = 4'($urandom_range(0, 15));
      exp_fail = rtt ^ TRUTH;
      run_dut("random", rtt, 3'($countones(exp_fail)), exp_fail, exp_fail == 4'b0000);
    end

    // start kept high into the run is ignored: exactly one done.
    gate_tt = 4'b1000;
    @(negedge clk); start = 1'b1; cyc = 0; ndone = 0; done_cyc = 0;
    while (cyc < 60) begin
      @(negedge clk); cyc++;
      if (cyc == 20) start = 1'b0;
      if (done) begin ndone++; done_cyc = cyc; end
    end
    chk("busy_start_ndone", 32'(ndone), 32'd1);
    chk("busy_start_cyc", 32'(done_cyc), 32'(4 * HOLD + 1));

    // start held continuously: one IDLE cycle, then the next run.
    @(negedge clk); start = 1'b1; cyc = 0; done_cyc = 0;
    while (cyc < 4 * HOLD + 3) begin
      @(negedge clk); cyc++;
      if (done) done_cyc = cyc;
      if (cyc == 4 * HOLD + 2) chk("b2b_idle_busy", 32'(busy), 32'd0);
    end
    chk("b2b_done_cyc", 32'(done_cyc), 32'(4 * HOLD + 1));
    chk("b2b_second_busy", 32'(busy), 32'd1);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    chk("b2b_second_done", 32'(done), 32'd1);
    @(negedge clk);

    // Reset in cycle 15 of a run with y stuck at 1 (vector 0 already failed).
    gate_tt = 4'b1111;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (cyc < 15) begin @(negedge clk); cyc++; end
    chk("pre_rst_state", {24'd0, a, b, busy, err_count, fail_vec},
        {24'd0, 1'b0, 1'b1, 1'b1, 3'd1, 4'b0001});
    rst = 1'b1;
    #1;
    chk("rst_midrun", {21'd0, a, b, busy, done, pass, err_count, fail_vec}, 32'd0);
    @(negedge clk); rst = 1'b0; ndone = 0;
    repeat (60) begin @(negedge clk); if (done) ndone++; end
    chk("rst_no_done", 32'(ndone), 32'd0);
    run_dut("after_rst", 4'b1000, 3'd0, 4'b0000, 1'b1);

    // XOR truth, HOLD=2, gate with one cycle of latency.
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0; cyc = 1;
    while (!done2 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("xor_done_cyc", 32'(cyc), 32'd9);
    chk("xor_result", {24'd0, pass2, err_count2, fail_vec2}, {24'd0, 1'b1, 3'd0, 4'b0000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
